// File: rtl/pipelined_add.sv
// pipelined_add: segmented-carry adder/subtractor with valid/ready handshakes.
//
// The WIDTH-bit carry chain is cut into SEGS slices of SW = WIDTH/SEGS bits.
// Stage k adds slice k using the carry registered by stage k-1, so a result
// appears SEGS cycles after it is accepted, at one op per cycle. Each stage
// carries the full operands and the partially built sum along with the op.
// The whole pipe advances together whenever the output register is empty or
// being drained; otherwise every stage and the outputs hold.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake (in_ready never depends on in_valid)
//   a, b, cin, sub      operands; sub=1 computes a-b and ignores cin
//   out_valid,out_ready output handshake
//   sum, cout, ovf      registered result, carry/no-borrow, signed overflow

module pipelined_add #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / SEGS;

  logic             advance;
  logic [WIDTH-1:0] bx;
  logic             cin_eff;

  // Per-stage state; index k is the register written by stage k.
  logic [WIDTH-1:0] a_q  [SEGS];
  logic [WIDTH-1:0] a_d  [SEGS];
  logic [WIDTH-1:0] bx_q [SEGS];
  logic [WIDTH-1:0] bx_d [SEGS];
  logic [WIDTH-1:0] s_q  [SEGS];
  logic [WIDTH-1:0] s_d  [SEGS];
  logic [SEGS-1:0]  c_q;
  logic [SEGS-1:0]  c_d;
  logic [SEGS-1:0]  v_q;
  logic [SEGS-1:0]  v_d;
  logic             ovf_q;
  logic             ovf_d;

  // Stage inputs, reused for every stage inside the loop below.
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] bx_in;
  logic [WIDTH-1:0] s_in;
  logic             c_in;
  logic             v_in;
  logic [SW:0]      slice;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Subtraction as a + ~b + 1.
  assign bx      = sub ? ~b : b;
  assign cin_eff = sub | cin;

  always_comb begin
    a_in  = '0;
    bx_in = '0;
    s_in  = '0;
    c_in  = 1'b0;
    v_in  = 1'b0;
    slice = '0;
    ovf_d = 1'b0;
    c_d   = '0;
    v_d   = '0;
    for (int k = 0; k < SEGS; k++) begin
      a_d[k]  = '0;
      bx_d[k] = '0;
      s_d[k]  = '0;
    end

    for (int k = 0; k < SEGS; k++) begin
      if (k == 0) begin
        a_in  = a;
        bx_in = bx;
        s_in  = '0;
        c_in  = cin_eff;
        v_in  = in_valid;
      end else begin
        a_in  = a_q[k-1];
        bx_in = bx_q[k-1];
        s_in  = s_q[k-1];
        c_in  = c_q[k-1];
        v_in  = v_q[k-1];
      end

      slice = {1'b0, a_in[k*SW +: SW]} + {1'b0, bx_in[k*SW +: SW]} + {{SW{1'b0}}, c_in};

      a_d[k]              = a_in;
      bx_d[k]             = bx_in;
      s_d[k]              = s_in;
      s_d[k][k*SW +: SW]  = slice[SW-1:0];
      c_d[k]              = slice[SW];
      v_d[k]              = v_in;

      // Overflow is resolved alongside the top slice so it registers with sum.
      if (k == SEGS - 1) begin
        ovf_d = (a_in[WIDTH-1] == bx_in[WIDTH-1]) & (s_d[k][WIDTH-1] != a_in[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SEGS; k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SEGS; k++) begin
        a_q[k]  <= a_d[k];
        bx_q[k] <= bx_d[k];
        s_q[k]  <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[SEGS-1];
  assign sum       = s_q[SEGS-1];
  assign cout      = c_q[SEGS-1];
  assign ovf       = ovf_q;

endmodule
